sig_edge_filter: RTL and testbench

Parameterised multi-channel successor to the single-bit edge detector used across the PSU controller. For each channel it synchronises an asynchronous input and rejects glitches with a stability filter. It detects rising, falling or both edges, selectable per channel, and drives a stretched output pulse and a sticky event flag. Typical users are the PID and fault-handling logic, which consume comparator, trip and enable inputs.

---
 rtl/sig_edge_filter.sv | 79 +++++++
 tb/tb_sig_edge_filter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sig_edge_filter.sv
// Multi-channel edge detector: synchronise, glitch-filter, then qualify edges per channel
// into a stretched pulse and a sticky event flag.
module sig_edge_filter #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int PULSE_LEN     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   sig_in,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   clr,
    output logic [CHANNELS-1:0]   level_out,
    output logic [CHANNELS-1:0]   pulse_out,
    output logic [CHANNELS-1:0]   event_flag
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam logic [FW-1:0] FILT_LAST  = FW'(FILTER_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_LEN);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic [FW-1:0]          filt_q, filt_d;
        logic                   level_q, level_d;
        logic [PW-1:0]          pcnt_q, pcnt_d;
        logic                   flag_q, flag_d;
        logic                   toggle;
        logic                   qualified;

        always_comb begin
            sync_d    = {sync_q[SYNC_STAGES-2:0], sig_in[i]};
            filt_d    = '0;
            level_d   = level_q;
            toggle    = 1'b0;
            // Acceptance happens on the edge the counter would reach FILTER_CYCLES.
            if (sync_q[SYNC_STAGES-1] != level_q) begin
                if (filt_q == FILT_LAST) begin
                    toggle  = 1'b1;
                    level_d = ~level_q;
                end else begin
                    filt_d = filt_q + FW'(1);
                end
            end
            // mode bit 2i enables rising edges, bit 2i+1 enables falling edges.
            qualified = toggle & ((level_d & mode[2*i]) | (~level_d & mode[2*i+1]));
            pcnt_d    = pcnt_q;
            if (qualified) begin
                pcnt_d = PULSE_LOAD;
            end else if (pcnt_q != '0) begin
                pcnt_d = pcnt_q - PW'(1);
            end
            flag_d    = qualified | (flag_q & ~clr[i]);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q  <= '0;
                filt_q  <= '0;
                level_q <= 1'b0;
                pcnt_q  <= '0;
                flag_q  <= 1'b0;
            end else begin
                sync_q  <= sync_d;
                filt_q  <= filt_d;
                level_q <= level_d;
                pcnt_q  <= pcnt_d;
                flag_q  <= flag_d;
            end
        end

        assign level_out[i]  = level_q;
        assign pulse_out[i]  = (pcnt_q != '0);
        assign event_flag[i] = flag_q;
    end

endmodule

// File: tb/tb_sig_edge_filter.sv
// Directed bench for sig_edge_filter: a default instance plus a single-channel
// instance with a short filter and a 5-cycle pulse.
module tb_sig_edge_filter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sig_in;
    logic [7:0] mode;
    logic [3:0] clr;
    logic [3:0] level_out, pulse_out, event_flag;

    logic [0:0] sig_p, clr_p;
    logic [1:0] mode_p;
    logic [0:0] level_p, pulse_p, flag_p;

    int n_checks = 0;
    int n_fail   = 0;

    sig_edge_filter dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .mode       (mode),
        .clr        (clr),
        .level_out  (level_out),
        .pulse_out  (pulse_out),
        .event_flag (event_flag)
    );

    sig_edge_filter #(
        .CHANNELS      (1),
        .SYNC_STAGES   (2),
        .FILTER_CYCLES (3),
        .PULSE_LEN     (5)
    ) dut_p (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_p),
        .mode       (mode_p),
        .clr        (clr_p),
        .level_out  (level_p),
        .pulse_out  (pulse_p),
        .event_flag (flag_p)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        rst    = 1'b1;
        sig_in = '0;
        clr    = '0;
        mode   = 8'b11_10_11_01;  // ch3 both, ch2 fall, ch1 both, ch0 rise
        sig_p  = '0;
        clr_p  = '0;
        mode_p = 2'b11;
        tick();
        tick();
        check_eq("rst_level", level_out, 0);
        check_eq("rst_pulse", pulse_out, 0);
        check_eq("rst_flag", event_flag, 0);
        check_eq("rst_p_pulse", pulse_p, 0);
        rst = 1'b0;

        // ch0 rise, default latency
        sig_in[0] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check_eq($sformatf("ch0_level_e%0d", e), level_out[0], (e >= 6));
            check_eq($sformatf("ch0_pulse_e%0d", e), pulse_out[0], (e == 6));
            check_eq($sformatf("ch0_flag_e%0d", e), event_flag[0], (e >= 6));
        end

        // ch1 3-cycle glitch is rejected
        sig_in[1] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 3) sig_in[1] = 1'b0;
            check_eq($sformatf("g3_level_e%0d", e), level_out[1], 0);
            check_eq($sformatf("g3_pulse_e%0d", e), pulse_out[1], 0);
            check_eq($sformatf("g3_flag_e%0d", e), event_flag[1], 0);
        end

        // ch1 4-cycle pulse is accepted: rise at edge 6, fall at edge 10
        sig_in[1] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 4) sig_in[1] = 1'b0;
            check_eq($sformatf("g4_level_e%0d", e), level_out[1], (e >= 6 && e < 10));
            check_eq($sformatf("g4_pulse_e%0d", e), pulse_out[1], (e == 6 || e == 10));
            check_eq($sformatf("g4_flag_e%0d", e), event_flag[1], (e >= 6));
        end

        // ch2 fall-only: high 10 cycles, rise at edge 6, fall at edge 16
        sig_in[2] = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            tick();
            if (e == 10) sig_in[2] = 1'b0;
            check_eq($sformatf("fall_level_e%0d", e), level_out[2], (e >= 6 && e < 16));
            check_eq($sformatf("fall_pulse_e%0d", e), pulse_out[2], (e == 16));
            check_eq($sformatf("fall_flag_e%0d", e), event_flag[2], (e >= 16));
        end

        clr[2] = 1'b1;
        tick();
        clr[2] = 1'b0;
        check_eq("ch2_clr", event_flag[2], 0);

        // ch2 mode off: level tracks, nothing reported
        mode[5:4] = 2'b00;
        sig_in[2] = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            tick();
            if (e == 10) sig_in[2] = 1'b0;
            check_eq($sformatf("off_level_e%0d", e), level_out[2], (e >= 6 && e < 16));
            check_eq($sformatf("off_pulse_e%0d", e), pulse_out[2], 0);
            check_eq($sformatf("off_flag_e%0d", e), event_flag[2], 0);
        end

        // ch3 clr coincident with qualified edge: set wins
        sig_in[3] = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check_eq($sformatf("ch3_flag_e%0d", e), event_flag[3], 0);
        end
        clr[3] = 1'b1;
        tick();
        check_eq("ch3_setwins_flag", event_flag[3], 1);
        check_eq("ch3_setwins_pulse", pulse_out[3], 1);
        tick();
        check_eq("ch3_clr_flag", event_flag[3], 0);
        clr[3] = 1'b0;
        tick();
        check_eq("ch3_hold_flag", event_flag[3], 0);

        // dut_p: toggles at edges 5 and 8 merge into one 8-cycle pulse
        sig_p = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (e == 3) sig_p = 1'b0;
            check_eq($sformatf("merge_level_e%0d", e), level_p, (e >= 5 && e < 8));
            check_eq($sformatf("merge_pulse_e%0d", e), pulse_p, (e >= 5 && e <= 12));
            check_eq($sformatf("merge_flag_e%0d", e), flag_p, (e >= 5));
        end

        // reset two cycles into a dut_p pulse; dut ch0 stays high through reset
        clr_p = 1'b1;
        tick();
        clr_p = 1'b0;
        sig_p = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check_eq($sformatf("pre_rst_pulse_e%0d", e), pulse_p, (e >= 5));
        end
        rst   = 1'b1;
        sig_p = 1'b0;
        tick();
        check_eq("rst_mid_p_pulse", pulse_p, 0);
        check_eq("rst_mid_p_level", level_p, 0);
        check_eq("rst_mid_p_flag", flag_p, 0);
        check_eq("rst_mid_level", level_out, 0);
        check_eq("rst_mid_pulse", pulse_out, 0);
        check_eq("rst_mid_flag", event_flag, 0);
        rst = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check_eq($sformatf("post_p_pulse_e%0d", e), pulse_p, 0);
            check_eq($sformatf("post_p_level_e%0d", e), level_p, 0);
            check_eq($sformatf("post_ch0_level_e%0d", e), level_out[0], (e >= 6));
            check_eq($sformatf("post_ch0_pulse_e%0d", e), pulse_out[0], (e == 6));
            check_eq($sformatf("post_ch0_flag_e%0d", e), event_flag[0], (e >= 6));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
